ccff_stream_loader: RTL

CCFF_STREAM_LOADER -- requirements
Module: ccff_stream_loader

---
 rtl/ccff_stream_loader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ccff_stream_loader.sv
//------------------------------------------------------------------------------
// ccff_stream_loader
//   Loads a serial configuration chain from a stream of WORD_W-bit words.
//   Each word is shifted out MSB first, and the bits returning from the tail of
//   the chain are captured into tail_word.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module ccff_stream_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 5
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              prog_clk_en,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] tail_word,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WL_W  = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] shift_reg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WL_W-1:0]   word_left;

    logic [CNT_W-1:0]  remaining;
    logic [WL_W-1:0]   load_len;
    logic              last_bit;

    // Bits still owed to the chain decide how much of the next word is used.
    assign remaining = CNT_W'(CHAIN_LEN) - bit_cnt;
    assign last_bit  = (bit_cnt == CNT_W'(CHAIN_LEN - 1));

    always_comb begin
        load_len = WL_W'(remaining);
        if (int'(remaining) > WORD_W) begin
            load_len = WL_W'(WORD_W);
        end
    end

    // prog_clk_en is high only in SHIFT, so it also gates the head bit.
    assign ccff_head = prog_clk_en & shift_reg[WORD_W-1];

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            word_left   <= '0;
            tail_word   <= '0;
            cfg_ready   <= 1'b0;
            prog_clk_en <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (prog_clk_en) begin
                tail_word <= {tail_word[WORD_W-2:0], ccff_tail};
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        bit_cnt   <= '0;
                        state     <= LOAD;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (cfg_valid) begin
                        shift_reg   <= cfg_data;
                        word_left   <= load_len;
                        state       <= SHIFT;
                        cfg_ready   <= 1'b0;
                        prog_clk_en <= 1'b1;
                    end
                end
                SHIFT: begin
                    shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
                    bit_cnt   <= bit_cnt + CNT_W'(1);
                    word_left <= word_left - WL_W'(1);
                    if (word_left == WL_W'(1)) begin
                        prog_clk_en <= 1'b0;
                        if (last_bit) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= LOAD;
                            cfg_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
